// File: rtl/saturn_bus_prog_builder_pkg.sv
// Shared definitions for the bus program builder: bus command codes, entry layout, FSM states.
package saturn_bus_prog_builder_pkg;

  localparam int ENTRY_W        = 5;
  localparam int ENTRY_FLAG_BIT = 4;

  localparam logic [3:0] BUSCMD_PC_READ  = 4'h0;
  localparam logic [3:0] BUSCMD_DP_READ  = 4'h1;
  localparam logic [3:0] BUSCMD_PC_WRITE = 4'h2;
  localparam logic [3:0] BUSCMD_DP_WRITE = 4'h3;
  localparam logic [3:0] BUSCMD_LOAD_PC  = 4'h4;
  localparam logic [3:0] BUSCMD_LOAD_DP  = 4'h5;
  localparam logic [3:0] BUSCMD_CONFIG   = 4'h6;
  localparam logic [3:0] BUSCMD_UNCONFIG = 4'h7;

  typedef enum logic [1:0] {
    BUSPROG_ST_IDLE = 2'd0,
    BUSPROG_ST_ADDR = 2'd1,
    BUSPROG_ST_DATA = 2'd2
  } busprog_state_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic is_cmd, input logic [3:0] nib);
    logic [ENTRY_W-1:0] e;
    e                 = '0;
    e[3:0]            = nib;
    e[ENTRY_FLAG_BIT] = is_cmd;
    return e;
  endfunction

endpackage

// File: rtl/saturn_bus_prog_fifo.sv
// Program-entry FIFO: storage, wrapping rd/wr pointers, count, full/empty and push/pop arbitration.
module saturn_bus_prog_fifo
  import saturn_bus_prog_builder_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_entry,
  input  logic               pop,
  output logic               can_push,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      diff;
  logic               pop_fire;
  logic               push_fire;

  // The extra pointer bit keeps full (diff == DEPTH) distinct from empty (diff == 0).
  assign diff      = wr_ptr - rd_ptr;
  assign empty     = (diff == '0);
  assign full      = (diff == PW'(DEPTH));
  assign count     = CNT_W'(diff);
  assign pop_fire  = en && pop && !empty;
  assign can_push  = !full || pop_fire;
  assign push_fire = en && push && can_push;
  assign head      = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/saturn_bus_prog_builder.sv
// Serialises bus requests (command, address nibbles, data nibbles) into a FIFO of program entries.
// Define SATURN_BUSPROG_DATA_EN to enable the data payload phase and its length-overflow error.
module saturn_bus_prog_builder
  import saturn_bus_prog_builder_pkg::*;
#(
  parameter int DEPTH            = 32,
  parameter int ADDR_NIBBLES     = 5,
  parameter int MAX_DATA_NIBBLES = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_clk_en,
  input  logic                                  i_req_valid,
  output logic                                  o_req_ready,
  input  logic [3:0]                            i_req_cmd,
  input  logic                                  i_req_addr_en,
  input  logic [4*ADDR_NIBBLES-1:0]             i_req_addr,
  input  logic [$clog2(MAX_DATA_NIBBLES+1)-1:0] i_req_data_len,
  input  logic [4*MAX_DATA_NIBBLES-1:0]         i_req_data,
  output logic                                  o_prog_valid,
  output logic [ENTRY_W-1:0]                    o_prog_entry,
  input  logic                                  i_prog_ack,
  output logic [$clog2(DEPTH+1)-1:0]            o_prog_count,
  output logic                                  o_busy,
  output logic                                  o_error
);
  localparam int LEN_W  = $clog2(MAX_DATA_NIBBLES + 1);
  localparam int AIDX_W = $clog2(ADDR_NIBBLES + 1);
  localparam int IDX_W  = (LEN_W > AIDX_W) ? LEN_W : AIDX_W;

  busprog_state_t            state, state_nxt;
  logic [IDX_W-1:0]          idx_q, idx_nxt;
  logic [4*ADDR_NIBBLES-1:0] addr_q, addr_nxt;
  logic                      error_q, error_nxt;
  logic                      push_req;
  logic [ENTRY_W-1:0]        push_entry;
  logic                      can_push;
  logic                      full;
  logic                      empty;
  logic                      accept;
  logic                      len_ovf;
  logic [LEN_W-1:0]          len_in;

`ifdef SATURN_BUSPROG_DATA_EN
  logic [4*MAX_DATA_NIBBLES-1:0] data_q, data_nxt;
  logic [LEN_W-1:0]              len_q, len_nxt;

  assign len_ovf = (i_req_data_len > LEN_W'(MAX_DATA_NIBBLES));
  assign len_in  = len_ovf ? LEN_W'(MAX_DATA_NIBBLES) : i_req_data_len;
`else
  wire unused_data = ^{i_req_data, i_req_data_len};
  assign len_ovf = 1'b0;
  assign len_in  = '0;
`endif

  // Request handshake: a request transfers on an enabled edge where i_req_valid && o_req_ready;
  // the command entry is pushed on that same edge, so a full FIFO withholds o_req_ready.
  assign o_req_ready  = (state == BUSPROG_ST_IDLE) && !full;
  assign accept       = i_req_valid && o_req_ready;
  assign o_busy       = (state != BUSPROG_ST_IDLE);
  assign o_prog_valid = !empty;
  assign o_error      = error_q;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx_q;
    addr_nxt   = addr_q;
    error_nxt  = error_q;
    push_req   = 1'b0;
    push_entry = '0;
`ifdef SATURN_BUSPROG_DATA_EN
    data_nxt   = data_q;
    len_nxt    = len_q;
`endif
    if (i_prog_ack && empty) error_nxt = 1'b1;

    case (state)
      BUSPROG_ST_IDLE: begin
        push_entry = make_entry(1'b1, i_req_cmd);
        if (accept) begin
          push_req = 1'b1;
          addr_nxt = i_req_addr;
          idx_nxt  = '0;
          if (len_ovf) error_nxt = 1'b1;
`ifdef SATURN_BUSPROG_DATA_EN
          data_nxt = i_req_data;
          len_nxt  = len_in;
`endif
          if (i_req_addr_en)     state_nxt = BUSPROG_ST_ADDR;
`ifdef SATURN_BUSPROG_DATA_EN
          else if (len_in != '0) state_nxt = BUSPROG_ST_DATA;
`endif
        end
      end
      BUSPROG_ST_ADDR: begin
        push_req   = 1'b1;
        push_entry = make_entry(1'b0, addr_q[3:0]);
        if (can_push) begin
          addr_nxt = addr_q >> 4;
          if (idx_q == IDX_W'(ADDR_NIBBLES - 1)) begin
            idx_nxt   = '0;
            state_nxt = BUSPROG_ST_IDLE;
`ifdef SATURN_BUSPROG_DATA_EN
            if (len_q != '0) state_nxt = BUSPROG_ST_DATA;
`endif
          end else begin
            idx_nxt = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef SATURN_BUSPROG_DATA_EN
      BUSPROG_ST_DATA: begin
        push_req   = 1'b1;
        push_entry = make_entry(1'b0, data_q[3:0]);
        if (can_push) begin
          data_nxt = data_q >> 4;
          if (idx_q + IDX_W'(1) == IDX_W'(len_q)) begin
            idx_nxt   = '0;
            state_nxt = BUSPROG_ST_IDLE;
          end else begin
            idx_nxt = idx_q + IDX_W'(1);
          end
        end
      end
`endif
      default: state_nxt = BUSPROG_ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= BUSPROG_ST_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      error_q <= 1'b0;
`ifdef SATURN_BUSPROG_DATA_EN
      data_q  <= '0;
      len_q   <= '0;
`endif
    end else if (i_clk_en) begin
      state   <= state_nxt;
      idx_q   <= idx_nxt;
      addr_q  <= addr_nxt;
      error_q <= error_nxt;
`ifdef SATURN_BUSPROG_DATA_EN
      data_q  <= data_nxt;
      len_q   <= len_nxt;
`endif
    end
  end

  saturn_bus_prog_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (i_clk),
    .reset      (i_reset),
    .en         (i_clk_en),
    .push       (push_req),
    .push_entry (push_entry),
    .pop        (i_prog_ack),
    .can_push   (can_push),
    .head       (o_prog_entry),
    .count      (o_prog_count),
    .full       (full),
    .empty      (empty)
  );

endmodule

// File: tb/tb_saturn_bus_prog_builder.sv
// Directed bench for saturn_bus_prog_builder with DEPTH = 8, five address nibbles, 16 data nibbles.
module tb_saturn_bus_prog_builder;

  localparam int DEPTH = 8;
  localparam int AN    = 5;
  localparam int MAXD  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_cmd;
  logic          req_addr_en;
  logic [4*AN-1:0]   req_addr;
  logic [4:0]        req_data_len;
  logic [4*MAXD-1:0] req_data;
  logic          prog_valid;
  logic [4:0]    prog_entry;
  logic          prog_ack;
  logic [3:0]    prog_count;
  logic          busy;
  logic          error;

  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  saturn_bus_prog_builder #(.DEPTH(DEPTH), .ADDR_NIBBLES(AN), .MAX_DATA_NIBBLES(MAXD)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_clk_en       (clk_en),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_cmd      (req_cmd),
    .i_req_addr_en  (req_addr_en),
    .i_req_addr     (req_addr),
    .i_req_data_len (req_data_len),
    .i_req_data     (req_data),
    .o_prog_valid   (prog_valid),
    .o_prog_entry   (prog_entry),
    .i_prog_ack     (prog_ack),
    .o_prog_count   (prog_count),
    .o_busy         (busy),
    .o_error        (error)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // driver: waits (bounded) for ready, presents one request for one edge
  task automatic send_req(input logic [3:0] cmd, input logic aen, input logic [19:0] addr,
                          input logic [4:0] len, input logic [63:0] data);
    int n;
    n = 0;
    while (!req_ready && n < 40) begin
      step();
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    req_cmd      = cmd;
    req_addr_en  = aen;
    req_addr     = addr;
    req_data_len = len;
    req_data     = data;
    req_valid    = 1'b1;
    step();
    req_valid    = 1'b0;
  endtask

  // consumer: one edge, popping and scoreboarding the head if present
  task automatic ack_cycle();
    logic [4:0] e;
    if (prog_valid) begin
      prog_ack = 1'b1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("entry", 32'(prog_entry), 32'(e));
      end else begin
        check("unexpected_entry", 32'(prog_entry), 32'h0);
      end
    end
    step();
    prog_ack = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      ack_cycle();
      n++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; req_valid = 1'b0; req_cmd = '0; req_addr_en = 1'b0;
    req_addr = '0; req_data_len = '0; req_data = '0; prog_ack = 1'b0;
    steps(2);
    reset = 1'b0;
    step();

    // reset state
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(prog_valid), 32'd0);
    check("rst_count", 32'(prog_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_entry", 32'(prog_entry), 32'd0);

    // LOAD_PC with address 0x12345
    exp_q = '{5'h14, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01};
    send_req(4'h4, 1'b1, 20'h12345, 5'd0, 64'h0);
    check("t1_valid", 32'(prog_valid), 32'd1);
    check("t1_count1", 32'(prog_count), 32'd1);
    check("t1_head", 32'(prog_entry), 32'h14);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready0", 32'(req_ready), 32'd0);
    steps(4);
    check("t1_ready_edge4", 32'(req_ready), 32'd0);
    step();
    check("t1_ready_edge5", 32'(req_ready), 32'd1);
    check("t1_count6", 32'(prog_count), 32'd6);
    check("t1_busy_done", 32'(busy), 32'd0);
    drain(20);
    check("t1_empty", 32'(prog_count), 32'd0);

    // data-only request, len 3, data 0xABC
`ifdef SATURN_BUSPROG_DATA_EN
    exp_q = '{5'h13, 5'h0C, 5'h0B, 5'h0A};
    send_req(4'h3, 1'b0, 20'h0, 5'd3, 64'hABC);
    steps(3);
    check("t2_count", 32'(prog_count), 32'd4);
`else
    exp_q = '{5'h13};
    send_req(4'h3, 1'b0, 20'h0, 5'd3, 64'hABC);
    check("t2_count", 32'(prog_count), 32'd1);
`endif
    check("t2_ready", 32'(req_ready), 32'd1);
    drain(20);

    // back-to-back 6-entry requests into an 8-deep FIFO
    exp_q = '{5'h15, 5'h0E, 5'h0D, 5'h0C, 5'h0B, 5'h0A,
              5'h14, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09};
    send_req(4'h5, 1'b1, 20'hABCDE, 5'd0, 64'h0);
    send_req(4'h4, 1'b1, 20'h98765, 5'd0, 64'h0);
    check("t3_count7", 32'(prog_count), 32'd7);
    steps(4);
    check("t3_stall_count", 32'(prog_count), 32'd8);
    check("t3_stall_busy", 32'(busy), 32'd1);
    check("t3_stall_ready", 32'(req_ready), 32'd0);
    check("t3_stall_head", 32'(prog_entry), 32'h15);
    for (int i = 0; i < 4; i++) begin
      ack_cycle();
      check("t3_pushpop_count", 32'(prog_count), 32'd8);
    end
    check("t3_busy_done", 32'(busy), 32'd0);
    drain(20);
    check("t3_empty", 32'(prog_count), 32'd0);

    // clock enable held low mid-request, with ack asserted
    exp_q = '{5'h12, 5'h09, 5'h07, 5'h05, 5'h03, 5'h01};
    send_req(4'h2, 1'b1, 20'h13579, 5'd0, 64'h0);
    step();
    check("t6_count2", 32'(prog_count), 32'd2);
    clk_en = 1'b0;
    prog_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_hold_count", 32'(prog_count), 32'd2);
      check("t6_hold_head", 32'(prog_entry), 32'h12);
      check("t6_hold_busy", 32'(busy), 32'd1);
    end
    prog_ack = 1'b0;
    clk_en = 1'b1;
    steps(4);
    check("t6_count6", 32'(prog_count), 32'd6);
    check("t6_busy_done", 32'(busy), 32'd0);
    drain(20);
    check("t6_error", 32'(error), 32'd0);

    // oversize data length
`ifdef SATURN_BUSPROG_DATA_EN
    exp_q = '{5'h13, 5'h0F, 5'h0E, 5'h0D, 5'h0C, 5'h0B, 5'h0A, 5'h09, 5'h08,
              5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00};
    send_req(4'h3, 1'b0, 20'h0, 5'd20, 64'h0123456789ABCDEF);
    drain(60);
    check("ovf_error", 32'(error), 32'd1);
`else
    exp_q = '{5'h13};
    send_req(4'h3, 1'b0, 20'h0, 5'd20, 64'h0123456789ABCDEF);
    drain(20);
    check("ovf_error", 32'(error), 32'd0);
`endif
    check("ovf_empty", 32'(prog_count), 32'd0);

    // reset mid-ADDR after two nibbles, then a clean request
    send_req(4'h4, 1'b1, 20'h12345, 5'd0, 64'h0);
    steps(2);
    check("t5_pre_count", 32'(prog_count), 32'd3);
    reset = 1'b1;
    step();
    check("t5_count", 32'(prog_count), 32'd0);
    check("t5_valid", 32'(prog_valid), 32'd0);
    check("t5_ready", 32'(req_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_error", 32'(error), 32'd0);
    reset = 1'b0;
    exp_q = '{5'h15, 5'h0A, 5'h00, 5'h0F, 5'h00, 5'h00};
    send_req(4'h5, 1'b1, 20'h00F0A, 5'd0, 64'h0);
    steps(5);
    check("t5_clean_count", 32'(prog_count), 32'd6);
    drain(20);

    // ack while empty
    check("t4_pre_error", 32'(error), 32'd0);
    prog_ack = 1'b1;
    step();
    prog_ack = 1'b0;
    check("t4_error", 32'(error), 32'd1);
    check("t4_count", 32'(prog_count), 32'd0);
    check("t4_valid", 32'(prog_valid), 32'd0);
    steps(3);
    check("t4_sticky", 32'(error), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t4_cleared", 32'(error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
